// File: rtl/aes_block_loader_if.sv
// Word-stream / block-handshake bundle between the host side and aes_block_loader.
// master: host/bench side driving words and the core-side ready.
// slave : the loader itself.
interface aes_block_loader_if #(
  parameter int unsigned BLK_W  = 128,
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              key_reload;
  logic [BLK_W-1:0]  key_out;
  logic [BLK_W-1:0]  data_out;
  logic              key_loaded;
  logic              blk_valid;
  logic              blk_ready;
  logic [15:0]       blk_count;

  modport master (
    output word_in, word_valid, key_reload, blk_ready,
    input  word_ready, key_out, data_out, key_loaded, blk_valid, blk_count
  );

  modport slave (
    input  word_in, word_valid, key_reload, blk_ready,
    output word_ready, key_out, data_out, key_loaded, blk_valid, blk_count
  );
endinterface

// File: rtl/aes_block_loader.sv
// aes_block_loader: packs WORD_W-bit words (MSW first) into a BLK_W-bit key and
// plaintext blocks and hands each key+block pair to the AES core with valid/ready.
// The key is loaded once and reused until key_reload is requested.
// Optional build macro: AES_LOADER_BSWAP_EN -- byte-reverse each accepted word
// before packing (little-endian host writing FIPS-197 byte order).
module aes_block_loader #(
  parameter int unsigned BLK_W  = 128,
  parameter int unsigned WORD_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  aes_block_loader_if.slave   bus
);

  localparam int unsigned NWORDS = BLK_W / WORD_W;
  localparam int unsigned CNT_W  = (NWORDS > 2) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_KEY   = 2'd0,
    S_DATA  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  word_cnt;
  logic              reload_pend;
  logic [BLK_W-1:0]  key_q;
  logic [BLK_W-1:0]  data_q;
  logic              key_loaded_q;
  logic              blk_valid_q;
  logic [15:0]       blk_count_q;
  logic [WORD_W-1:0] word_packed;
  logic              word_take;

`ifdef AES_LOADER_BSWAP_EN
  // Byte-reverse the incoming word: byte 0 of the bus lands in the top byte.
  always_comb begin
    word_packed = '0;
    for (int unsigned i = 0; i < WORD_W / 8; i++) begin
      word_packed[i*8 +: 8] = bus.word_in[WORD_W-8-i*8 +: 8];
    end
  end
`else
  assign word_packed = bus.word_in;
`endif

  // Ready decodes from state only, so there is no path from word_valid.
  assign bus.word_ready = (state != S_ISSUE);
  assign word_take      = bus.word_valid && (state != S_ISSUE);

  assign bus.key_out    = key_q;
  assign bus.data_out   = data_q;
  assign bus.key_loaded = key_loaded_q;
  assign bus.blk_valid  = blk_valid_q;
  assign bus.blk_count  = blk_count_q;

  // Load/issue FSM; key_reload always takes priority over a same-cycle word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_KEY;
      word_cnt     <= '0;
      reload_pend  <= 1'b0;
      key_q        <= '0;
      data_q       <= '0;
      key_loaded_q <= 1'b0;
      blk_valid_q  <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      case (state)
        S_KEY: begin
          if (bus.key_reload) begin
            word_cnt <= '0;
            key_q    <= '0;
          end else if (word_take) begin
            key_q <= {key_q[BLK_W-WORD_W-1:0], word_packed};
            if (word_cnt == LAST_CNT) begin
              word_cnt     <= '0;
              key_loaded_q <= 1'b1;
              state        <= S_DATA;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end

        S_DATA: begin
          if (bus.key_reload) begin
            word_cnt     <= '0;
            data_q       <= '0;
            key_loaded_q <= 1'b0;
            state        <= S_KEY;
          end else if (word_take) begin
            data_q <= {data_q[BLK_W-WORD_W-1:0], word_packed};
            if (word_cnt == LAST_CNT) begin
              word_cnt    <= '0;
              blk_valid_q <= 1'b1;
              state       <= S_ISSUE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end

        S_ISSUE: begin
          // A reload arriving on the handshake cycle itself is honoured as if pending.
          if (bus.blk_ready) begin
            blk_valid_q <= 1'b0;
            blk_count_q <= blk_count_q + 16'd1;
            reload_pend <= 1'b0;
            if (reload_pend || bus.key_reload) begin
              key_loaded_q <= 1'b0;
              state        <= S_KEY;
            end else begin
              state <= S_DATA;
            end
          end else if (bus.key_reload) begin
            reload_pend <= 1'b1;
          end
        end

        default: begin
          state    <= S_KEY;
          word_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader.
module tb_aes_block_loader;

  logic clk = 1'b0;
  logic reset;
  int unsigned checks = 0;
  int unsigned errors = 0;

  aes_block_loader_if #(.BLK_W(128), .WORD_W(32)) bus ();

  aes_block_loader #(.BLK_W(128), .WORD_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Host word carrying logical (packed) value p.
  function automatic logic [31:0] to_host(input logic [31:0] p);
`ifdef AES_LOADER_BSWAP_EN
    return {p[7:0], p[15:8], p[23:16], p[31:24]};
`else
    return p;
`endif
  endfunction

  // All tasks start and end at posedge+1.
  task automatic send_word(input logic [31:0] w);
    bus.word_valid = 1'b1;
    bus.word_in    = w;
    @(posedge clk); #1;
    bus.word_valid = 1'b0;
  endtask

  task automatic send_packed(input logic [7:0] tag, output logic [127:0] exp);
    logic [31:0] p;
    exp = '0;
    for (int i = 0; i < 4; i++) begin
      p   = {tag, 8'(i), 16'hA5C3};
      exp = {exp[95:0], p};
      send_word(to_host(p));
    end
  endtask

  task automatic handshake();
    bus.blk_ready = 1'b1;
    @(posedge clk); #1;
    bus.blk_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_key"},   bus.key_out,    '0);
    check({tag, "_data"},  bus.data_out,   '0);
    check({tag, "_kl"},    128'(bus.key_loaded), 128'd0);
    check({tag, "_bv"},    128'(bus.blk_valid),  128'd0);
    check({tag, "_cnt"},   128'(bus.blk_count),  128'd0);
    check({tag, "_wr"},    128'(bus.word_ready), 128'd1);
  endtask

  logic [31:0]  t1_words [8];
  logic [127:0] exp_key, exp_key2, exp_data, held;

  task automatic send_t1();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t1_bv_before_last", 128'(bus.blk_valid), 128'd0);
      send_word(t1_words[i]);
    end
  endtask

  initial begin
`ifdef AES_LOADER_BSWAP_EN
    t1_words = '{32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                 32'h33221100, 32'h77665544, 32'hbbaa9988, 32'hffeeddcc};
`else
    t1_words = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
`endif
    reset          = 1'b1;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.key_reload = 1'b0;
    bus.blk_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals("rst");

    // 1: key then first block
    send_t1();
    check("t1_key",  bus.key_out,  128'h000102030405060708090a0b0c0d0e0f);
    check("t1_kl",   128'(bus.key_loaded), 128'd1);
    check("t1_data", bus.data_out, 128'h00112233445566778899aabbccddeeff);
    check("t1_bv",   128'(bus.blk_valid),  128'd1);
    check("t1_wr",   128'(bus.word_ready), 128'd0);
    handshake();
    check("t1_cnt",  128'(bus.blk_count),  128'd1);
    check("t1_bv_off", 128'(bus.blk_valid), 128'd0);
    check("t1_wr_on",  128'(bus.word_ready), 128'd1);
    exp_key = 128'h000102030405060708090a0b0c0d0e0f;

    // 2: backpressure for 5 cycles with word_valid held high
    send_packed(8'h21, exp_data);
    check("t2_data", bus.data_out, exp_data);
    held = bus.data_out;
    bus.word_valid = 1'b1;
    bus.word_in    = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("t2_wr_low",  128'(bus.word_ready), 128'd0);
      check("t2_bv_high", 128'(bus.blk_valid),  128'd1);
      check("t2_stable",  bus.data_out, exp_data);
    end
    handshake();
    bus.word_valid = 1'b0;
    check("t2_cnt", 128'(bus.blk_count), 128'd2);
    check("t2_bv_off", 128'(bus.blk_valid), 128'd0);
    check("t2_wr_on", 128'(bus.word_ready), 128'd1);

    // 3: further blocks reuse the key without new key words
    for (int b = 0; b < 2; b++) begin
      send_packed(8'h30 + 8'(b), exp_data);
      check("t3_bv",   128'(bus.blk_valid), 128'd1);
      check("t3_data", bus.data_out, exp_data);
      check("t3_key",  bus.key_out,  exp_key);
      handshake();
    end
    check("t3_cnt", 128'(bus.blk_count), 128'd4);

    // 4: reload after two data words; same-cycle word is dropped
    send_word(to_host(32'h40000001));
    send_word(to_host(32'h40000002));
    bus.key_reload = 1'b1;
    bus.word_valid = 1'b1;
    bus.word_in    = 32'h99999999;
    @(posedge clk); #1;
    bus.key_reload = 1'b0;
    bus.word_valid = 1'b0;
    check("t4_kl0",  128'(bus.key_loaded), 128'd0);
    check("t4_bv0",  128'(bus.blk_valid),  128'd0);
    check("t4_wr",   128'(bus.word_ready), 128'd1);
    check("t4_key_hold", bus.key_out, exp_key);
    send_packed(8'h4B, exp_key2);
    check("t4_kl1",  128'(bus.key_loaded), 128'd1);
    check("t4_key2", bus.key_out, exp_key2);
    check("t4_bv_none", 128'(bus.blk_valid), 128'd0);
    send_packed(8'h4D, exp_data);
    check("t4_data", bus.data_out, exp_data);
    check("t4_bv",   128'(bus.blk_valid), 128'd1);
    handshake();
    check("t4_cnt",  128'(bus.blk_count), 128'd5);

    // 5: reload during issue with blk_ready low
    send_packed(8'h50, exp_data);
    bus.key_reload = 1'b1;
    @(posedge clk); #1;
    bus.key_reload = 1'b0;
    @(posedge clk); #1;
    check("t5_bv_hold", 128'(bus.blk_valid),  128'd1);
    check("t5_kl_hold", 128'(bus.key_loaded), 128'd1);
    check("t5_data",    bus.data_out, exp_data);
    handshake();
    check("t5_cnt", 128'(bus.blk_count),  128'd6);
    check("t5_kl0", 128'(bus.key_loaded), 128'd0);
    check("t5_wr",  128'(bus.word_ready), 128'd1);
    check("t5_bv0", 128'(bus.blk_valid),  128'd0);

    // 6: reset mid-block and mid-issue
    send_packed(8'h6A, exp_key2);
    send_word(to_host(32'h60000001));
    send_word(to_host(32'h60000002));
    pulse_reset();
    check_reset_vals("t6_midblk");
    send_t1();
    check("t6_bv_pre", 128'(bus.blk_valid), 128'd1);
    pulse_reset();
    check_reset_vals("t6_midiss");
    send_t1();
    check("t6_key",  bus.key_out,  128'h000102030405060708090a0b0c0d0e0f);
    check("t6_data", bus.data_out, 128'h00112233445566778899aabbccddeeff);
    handshake();
    check("t6_cnt",  128'(bus.blk_count), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
